// File: rtl/ddfs_chirp_sweeper.sv
// DDFS core with a linear chirp engine.
// A tuning word steps from a start value towards a stop value at the chirp
// rate, in one-shot, repeat or bounce mode. The word is phase-accumulated at
// the sample rate, and the top ADDR_W phase bits form the sine-LUT address.
module ddfs_chirp_sweeper #(
    parameter int FTW_W       = 16,
    parameter int ADDR_W      = 8,
    parameter int SYS_FREQ    = 50000000,
    parameter int SAMPLE_FREQ = 96000,
    parameter int CHIRP_RATE  = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [FTW_W-1:0]  ftw_start,
    input  logic [FTW_W-1:0]  ftw_step,
    input  logic [FTW_W-1:0]  ftw_stop,
    output logic [FTW_W-1:0]  q_ftw,
    output logic [ADDR_W-1:0] q_lut_address,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam int SAMPLE_DIV = SYS_FREQ / SAMPLE_FREQ;
    localparam int CHIRP_DIV  = SYS_FREQ / CHIRP_RATE;
    localparam int SC_W       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CC_W       = (CHIRP_DIV > 1) ? $clog2(CHIRP_DIV) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SAMPLE_DIV - 1);
    localparam logic [CC_W-1:0] CC_MAX = CC_W'(CHIRP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP_UP,
        ST_SWEEP_DOWN,
        ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [SC_W-1:0]    scnt_q, scnt_d;
    logic [CC_W-1:0]    ccnt_q, ccnt_d;
    logic [FTW_W-1:0]   phase_q, phase_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               sv_q, sv_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [FTW_W-1:0]   start_r_q, start_r_d;
    logic [FTW_W-1:0]   step_r_q, step_r_d;
    logic [FTW_W-1:0]   stop_r_q, stop_r_d;
    logic [1:0]         mode_r_q, mode_r_d;

    logic               sample_tick;
    logic               chirp_tick;
    logic               sweeping;
    logic               launch;
    logic [FTW_W-1:0]   phase_acc;
    logic [FTW_W:0]     sum_up;
    logic [FTW_W:0]     down_floor;

    assign sample_tick = (scnt_q == SC_MAX);
    assign sweeping    = (state_q == ST_SWEEP_UP) || (state_q == ST_SWEEP_DOWN);
    assign chirp_tick  = sweeping && (ccnt_q == CC_MAX);
    assign launch      = start && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign phase_acc   = phase_q + ftw_q;
    assign sum_up      = {1'b0, ftw_q} + {1'b0, step_r_q};
    assign down_floor  = {1'b0, start_r_q} + {1'b0, step_r_q};

    // Next-state logic: counters, phase accumulator and chirp FSM.
    // Priority is abort, then launch, then chirp tick.
    always_comb begin
        state_d   = state_q;
        scnt_d    = sample_tick ? '0 : scnt_q + SC_W'(1);
        ccnt_d    = sweeping ? (chirp_tick ? '0 : ccnt_q + CC_W'(1)) : '0;
        phase_d   = phase_q;
        ftw_d     = ftw_q;
        addr_d    = addr_q;
        sv_d      = 1'b0;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        start_r_d = start_r_q;
        step_r_d  = step_r_q;
        stop_r_d  = stop_r_q;
        mode_r_d  = mode_r_q;

        // Phase uses the pre-update tuning word when a chirp step coincides.
        if (sample_tick && (state_q != ST_IDLE)) begin
            phase_d = phase_acc;
            addr_d  = phase_acc[FTW_W-1 -: ADDR_W];
            sv_d    = 1'b1;
        end

        if (abort) begin
            state_d = ST_IDLE;
            ftw_d   = '0;
            ccnt_d  = '0;
            phase_d = phase_q;
            addr_d  = addr_q;
            sv_d    = 1'b0;
        end else if (launch) begin
            start_r_d = ftw_start;
            step_r_d  = ftw_step;
            stop_r_d  = ftw_stop;
            mode_r_d  = mode;
            ftw_d     = ftw_start;
            phase_d   = '0;
            addr_d    = addr_q;
            sv_d      = 1'b0;
            ccnt_d    = '0;
            if (ftw_stop <= ftw_start) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end else begin
                state_d = ST_SWEEP_UP;
            end
        end else if (chirp_tick) begin
            if (state_q == ST_SWEEP_UP) begin
                if (sum_up >= {1'b0, stop_r_q}) begin
                    case (mode_r_q)
                        2'd1: begin
                            ftw_d  = start_r_q;
                            wrap_d = 1'b1;
                        end
                        2'd2: begin
                            ftw_d   = stop_r_q;
                            state_d = ST_SWEEP_DOWN;
                        end
                        default: begin
                            ftw_d   = stop_r_q;
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    ftw_d = sum_up[FTW_W-1:0];
                end
            end else begin
                if ({1'b0, ftw_q} < down_floor) begin
                    ftw_d   = start_r_q;
                    state_d = ST_SWEEP_UP;
                    wrap_d  = 1'b1;
                end else begin
                    ftw_d = ftw_q - step_r_q;
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            ccnt_q    <= '0;
            phase_q   <= '0;
            ftw_q     <= '0;
            addr_q    <= '0;
            sv_q      <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            start_r_q <= '0;
            step_r_q  <= '0;
            stop_r_q  <= '0;
            mode_r_q  <= '0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            ccnt_q    <= ccnt_d;
            phase_q   <= phase_d;
            ftw_q     <= ftw_d;
            addr_q    <= addr_d;
            sv_q      <= sv_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            start_r_q <= start_r_d;
            step_r_q  <= step_r_d;
            stop_r_q  <= stop_r_d;
            mode_r_q  <= mode_r_d;
        end
    end

    assign q_ftw         = ftw_q;
    assign q_lut_address = addr_q;
    assign sample_valid  = sv_q;
    assign busy          = sweeping;
    assign done          = done_q;
    assign wrap          = wrap_q;

endmodule

// File: tb/tb_ddfs_chirp_sweeper.sv
// Scoreboard bench for ddfs_chirp_sweeper with shortened clock dividers
// (SAMPLE_DIV=10, CHIRP_DIV=100).
module tb_ddfs_chirp_sweeper;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] ftw_start = '0;
    logic [15:0] ftw_step = '0;
    logic [15:0] ftw_stop = '0;
    logic [15:0] q_ftw;
    logic [7:0]  q_lut_address;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic        wrap;

    ddfs_chirp_sweeper #(
        .FTW_W(16),
        .ADDR_W(8),
        .SYS_FREQ(1000),
        .SAMPLE_FREQ(100),
        .CHIRP_RATE(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .ftw_start(ftw_start),
        .ftw_step(ftw_step),
        .ftw_stop(ftw_stop),
        .q_ftw(q_ftw),
        .q_lut_address(q_lut_address),
        .sample_valid(sample_valid),
        .busy(busy),
        .done(done),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ftw;
        logic        done;
        logic        wrap;
        logic        busy;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] addr_exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         sv_count = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] f, input logic d, input logic w, input logic b);
        ev_t e;
        e.ftw  = f;
        e.done = d;
        e.wrap = w;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Monitor: an event is any q_ftw change or a done/wrap pulse.
    initial begin
        logic [15:0] prev;
        ev_t         e;
        logic [7:0]  ea;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sample_valid) begin
                    sv_count++;
                    if (addr_exp_q.size() > 0) begin
                        ea = addr_exp_q.pop_front();
                        chk("lut_address", {24'd0, q_lut_address}, {24'd0, ea});
                    end
                end
                if ((q_ftw !== prev) || done || wrap) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got ftw=0x%0h done=%0b wrap=%0b busy=%0b, expected no event",
                                 q_ftw, done, wrap, busy);
                    end else begin
                        e = exp_q.pop_front();
                        if ({q_ftw, done, wrap, busy} !== e) begin
                            n_fail++;
                            $display("FAIL event: got ftw=0x%0h done=%0b wrap=%0b busy=%0b, expected ftw=0x%0h done=%0b wrap=%0b busy=%0b",
                                     q_ftw, done, wrap, busy, e.ftw, e.done, e.wrap, e.busy);
                        end
                    end
                end
            end
            prev = q_ftw;
        end
    end

    task automatic launch(input logic [1:0] m, input logic [15:0] s, input logic [15:0] st,
                          input logic [15:0] sp);
        @(posedge clk);
        #1;
        mode      = m;
        ftw_start = s;
        ftw_step  = st;
        ftw_stop  = sp;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode      = ~m;
        ftw_start = 16'hFFFF;
        ftw_step  = 16'h0100;
        ftw_stop  = 16'h0001;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i;
        i = 0;
        while ((exp_q.size() > 0) && (i < limit)) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ftw(input string name, input logic [15:0] val, input int limit);
        int i;
        i = 0;
        while ((q_ftw !== val) && (i < limit)) begin
            @(negedge clk);
            i++;
        end
        chk(name, {16'd0, q_ftw}, {16'd0, val});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] addr_hold;
        int         i;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ftw", {16'd0, q_ftw}, 32'd0);
        chk("rst_addr", {24'd0, q_lut_address}, 32'd0);
        chk("rst_flags", {28'd0, sample_valid, busy, done, wrap}, 32'd0);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("idle_no_samples_ftw", {16'd0, q_ftw}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;

        // Test 1: one-shot sweep 0x012C -> 0x0200 by 7
        addr_exp_q.push_back(8'h01);
        addr_exp_q.push_back(8'h02);
        push(16'h012C, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) push(16'(16'h012C + 7 * k), 1'b0, 1'b0, 1'b1);
        push(16'h0200, 1'b1, 1'b0, 1'b0);
        launch(2'd0, 16'h012C, 16'h0007, 16'h0200);
        wait_drain("oneshot_drain", 3300);
        chk("oneshot_addr_drain", addr_exp_q.size(), 0);
        repeat (150) @(negedge clk);
        chk("oneshot_hold_busy", {31'd0, busy}, 32'd0);

        // Test 2: repeat mode, relaunched from HOLD
        push(16'h012C, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) push(16'(16'h012C + 7 * k), 1'b0, 1'b0, 1'b1);
        push(16'h012C, 1'b0, 1'b1, 1'b1);
        push(16'h0133, 1'b0, 1'b0, 1'b1);
        push(16'h013A, 1'b0, 1'b0, 1'b1);
        launch(2'd1, 16'h012C, 16'h0007, 16'h0200);
        wait_drain("repeat_drain", 3500);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_drain("repeat_abort", 5);

        // Test 3: bounce mode
        push(16'h012C, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) push(16'(16'h012C + 7 * k), 1'b0, 1'b0, 1'b1);
        push(16'h0200, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) push(16'(16'h0200 - 7 * k), 1'b0, 1'b0, 1'b1);
        push(16'h012C, 1'b0, 1'b1, 1'b1);
        launch(2'd2, 16'h012C, 16'h0007, 16'h0200);
        wait_drain("bounce_drain", 6600);
        push(16'h0133, 1'b0, 1'b0, 1'b1);
        wait_ftw("bounce_resume", 16'h0133, 150);

        // Test 5: abort with start on the chirp-tick edge
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        abort     = 1'b1;
        start     = 1'b1;
        mode      = 2'd0;
        ftw_start = 16'h0300;
        ftw_step  = 16'h0001;
        ftw_stop  = 16'h0400;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_ftw", {16'd0, q_ftw}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        addr_hold = q_lut_address;
        sv_count  = 0;
        repeat (250) @(negedge clk);
        chk("abort_no_samples", sv_count, 0);
        chk("abort_addr_hold", {24'd0, q_lut_address}, {24'd0, addr_hold});
        chk("abort_queue", exp_q.size(), 0);

        // Test 4: stop <= start goes straight to HOLD
        push(16'h0200, 1'b1, 1'b0, 1'b0);
        addr_exp_q.push_back(8'h02);
        addr_exp_q.push_back(8'h04);
        addr_exp_q.push_back(8'h06);
        addr_exp_q.push_back(8'h08);
        launch(2'd0, 16'h0200, 16'h0007, 16'h0100);
        i = 0;
        while ((addr_exp_q.size() > 0) && (i < 45)) begin
            @(negedge clk);
            i++;
        end
        chk("hold_samples_drain", addr_exp_q.size(), 0);
        addr_exp_q.delete();
        wait_drain("hold_drain", 5);
        chk("hold_busy", {31'd0, busy}, 32'd0);
        chk("hold_ftw", {16'd0, q_ftw}, 32'h0200);

        // Test 6: asynchronous reset mid-sweep
        push(16'h012C, 1'b0, 1'b0, 1'b1);
        push(16'h0133, 1'b0, 1'b0, 1'b1);
        launch(2'd0, 16'h012C, 16'h0007, 16'h0200);
        wait_ftw("pre_reset_step", 16'h0133, 150);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ftw", {16'd0, q_ftw}, 32'd0);
        chk("async_rst_addr", {24'd0, q_lut_address}, 32'd0);
        chk("async_rst_flags", {28'd0, sample_valid, busy, done, wrap}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        sv_count = 0;
        repeat (300) @(negedge clk);
        chk("post_rst_no_samples", sv_count, 0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ftw", {16'd0, q_ftw}, 32'd0);
        chk("final_event_queue", exp_q.size(), 0);
        chk("final_addr_queue", addr_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
